// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes and
// default latencies used by the Execute-stage decode and the unit itself.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Width of a down-counter that must hold the larger of the two latencies.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int max_cycles;
    max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit:
// request (start, op, operands) one way, busy/stall and HI/LO the other way.
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_data, rt_data,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, md_op, rs_data, rt_data,
    output busy, md_stall, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: latches a 64-bit result at acceptance and commits it
// to HI/LO after MULT_CYCLES/DIV_CYCLES. Define MDU_MADD_EN to enable madd/msub ops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  md
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             res_wr_q, res_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             busy;
  logic             compute_op;
  md_op_e           op;

  logic [63:0]      prod_s, prod_u, acc;
  logic [31:0]      dvd_mag, dvs_mag, dvs_mag_safe, rt_safe;
  logic [31:0]      quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

  assign op   = md_op_e'(md.md_op);
  assign busy = (cnt_q != '0);

  always_comb begin
    compute_op = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: compute_op = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: compute_op = 1'b1;
`endif
      default: compute_op = 1'b0;
    endcase
  end

  // Products: sign-extend for the signed flavour, the low 64 bits are exact.
  assign prod_s = {{32{md.rs_data[31]}}, md.rs_data} * {{32{md.rt_data[31]}}, md.rt_data};
  assign prod_u = {32'd0, md.rs_data} * {32'd0, md.rt_data};
  assign acc    = {hi_q, lo_q};

  // Signed divide on magnitudes; 0x80000000 as an unsigned magnitude is 2^31,
  // so the 0x80000000 / -1 case wraps to quotient 0x80000000, remainder 0.
  assign dvd_mag      = md.rs_data[31] ? (32'd0 - md.rs_data) : md.rs_data;
  assign dvs_mag      = md.rt_data[31] ? (32'd0 - md.rt_data) : md.rt_data;
  assign dvs_mag_safe = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
  assign rt_safe      = (md.rt_data == 32'd0) ? 32'd1 : md.rt_data;

  assign quo_mag = dvd_mag / dvs_mag_safe;
  assign rem_mag = dvd_mag % dvs_mag_safe;
  assign quo_s   = (md.rs_data[31] ^ md.rt_data[31]) ? (32'd0 - quo_mag) : quo_mag;
  assign rem_s   = md.rs_data[31] ? (32'd0 - rem_mag) : rem_mag;
  assign quo_u   = md.rs_data / rt_safe;
  assign rem_u   = md.rs_data % rt_safe;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    cnt_d    = cnt_q;

    if (busy) begin
      // start during busy is ignored: only the countdown advances
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1) && res_wr_q) begin
        hi_d = res_hi_q;
        lo_d = res_lo_q;
      end
    end else if (md.start) begin
      case (op)
        MD_MTHI: hi_d = md.rs_data;
        MD_MTLO: lo_d = md.rs_data;
        MD_MULT: begin
          {res_hi_d, res_lo_d} = prod_s;
          res_wr_d = 1'b1;
          cnt_d    = CNT_W'(MULT_CYCLES);
        end
        MD_MULTU: begin
          {res_hi_d, res_lo_d} = prod_u;
          res_wr_d = 1'b1;
          cnt_d    = CNT_W'(MULT_CYCLES);
        end
        MD_DIV: begin
          res_hi_d = rem_s;
          res_lo_d = quo_s;
          res_wr_d = (md.rt_data != 32'd0);
          cnt_d    = CNT_W'(DIV_CYCLES);
        end
        MD_DIVU: begin
          res_hi_d = rem_u;
          res_lo_d = quo_u;
          res_wr_d = (md.rt_data != 32'd0);
          cnt_d    = CNT_W'(DIV_CYCLES);
        end
`ifdef MDU_MADD_EN
        MD_MADD: begin
          {res_hi_d, res_lo_d} = acc + prod_s;
          res_wr_d = 1'b1;
          cnt_d    = CNT_W'(MULT_CYCLES);
        end
        MD_MADDU: begin
          {res_hi_d, res_lo_d} = acc + prod_u;
          res_wr_d = 1'b1;
          cnt_d    = CNT_W'(MULT_CYCLES);
        end
        MD_MSUB: begin
          {res_hi_d, res_lo_d} = acc - prod_s;
          res_wr_d = 1'b1;
          cnt_d    = CNT_W'(MULT_CYCLES);
        end
        MD_MSUBU: begin
          {res_hi_d, res_lo_d} = acc - prod_u;
          res_wr_d = 1'b1;
          cnt_d    = CNT_W'(MULT_CYCLES);
        end
`endif
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_wr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign md.busy     = busy;
  assign md.md_stall = (md.start && compute_op) || busy;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule
